// File: rtl/tdm_mux.sv
// Registered N-channel, W-bit selector with manual select and an automatic
// time-division scan that dwells DWELL enabled cycles per channel.
module tdm_mux #(
  parameter  int N_CH  = 4,
  parameter  int W     = 1,
  parameter  int DWELL = 1,
  localparam int SEL_W = $clog2(N_CH),
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] din,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              en,
  output logic [W-1:0]      f,
  output logic [SEL_W-1:0]  ch,
  output logic              wrap
);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } mode_e;

  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [SEL_W-1:0] ch_next;
  logic             wrap_next;
  logic [W-1:0]     f_next;

  // Next-channel decision; the wrap is explicit at LAST_CH so that
  // non-power-of-two channel counts never expose an unused index.
  always_comb begin
    ch_next   = ch;
    cnt_next  = cnt;
    wrap_next = 1'b0;
    if (mode_e'(mode) == MANUAL) begin
      if ({1'b0, sel} < N_CH_EXT) begin
        ch_next = sel;
      end
      cnt_next = '0;
    end else if (en) begin
      if (cnt == LAST_CNT) begin
        cnt_next = '0;
        if (ch == LAST_CH) begin
          ch_next   = '0;
          wrap_next = 1'b1;
        end else begin
          ch_next = ch + SEL_W'(1);
        end
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  // Data is picked with the same index that will be registered into ch,
  // keeping f and ch aligned in every cycle.
  always_comb begin
    f_next = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_next == SEL_W'(k)) begin
        f_next = din[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch   <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
      f    <= '0;
    end else begin
      ch   <= ch_next;
      cnt  <= cnt_next;
      wrap <= wrap_next;
      f    <= f_next;
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// Directed bench for tdm_mux: a 4x8-bit DWELL=3 instance for the main
// features and a 3x8-bit DWELL=1 instance for the non-power-of-two boundary.
module tb_tdm_mux;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        rst_n;
  logic [31:0] din;
  logic        mode;
  logic [1:0]  sel;
  logic        en;
  logic [7:0]  f;
  logic [1:0]  ch;
  logic        wrap;

  logic        rst3_n;
  logic [23:0] din3;
  logic        mode3;
  logic [1:0]  sel3;
  logic        en3;
  logic [7:0]  f3;
  logic [1:0]  ch3;
  logic        wrap3;

  tdm_mux #(.N_CH(4), .W(8), .DWELL(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel), .en(en),
    .f(f), .ch(ch), .wrap(wrap)
  );

  tdm_mux #(.N_CH(3), .W(8), .DWELL(1)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .din(din3), .mode(mode3), .sel(sel3), .en(en3),
    .f(f3), .ch(ch3), .wrap(wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] data4(input int c);
    case (c)
      0: data4 = 8'hA0;
      1: data4 = 8'hB1;
      2: data4 = 8'hC2;
      default: data4 = 8'hD3;
    endcase
  endfunction

  function automatic logic [7:0] data3(input int c);
    case (c)
      0: data3 = 8'h11;
      1: data3 = 8'h22;
      default: data3 = 8'h33;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({ch, f, wrap} !== {2'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset4: ch=%0d f=%h wrap=%b, expected ch=0 f=00 wrap=0", ch, f, wrap);
    end
    n_checks++;
    if ({ch3, f3, wrap3} !== {2'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset3: ch=%0d f=%h wrap=%b, expected ch=0 f=00 wrap=0", ch3, f3, wrap3);
    end
  endtask

  task automatic test_manual();
    sel   = 2'd2;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({ch, f, wrap} !== {2'd2, 8'hC2, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL manual_sel2: ch=%0d f=%h wrap=%b, expected ch=2 f=c2 wrap=0", ch, f, wrap);
    end
    din[23:16] = 8'h55;
    step();
    n_checks++;
    if ({ch, f} !== {2'd2, 8'h55}) begin
      n_fail++;
      $display("[TB] FAIL manual_din_track: ch=%0d f=%h, expected ch=2 f=55", ch, f);
    end
    din[23:16] = 8'hC2;
    sel = 2'd3;
    en  = 1'b1;
    step();
    n_checks++;
    if ({ch, f, wrap} !== {2'd3, 8'hD3, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL manual_sel3: ch=%0d f=%h wrap=%b, expected ch=3 f=d3 wrap=0", ch, f, wrap);
    end
    sel = 2'd0;
    step();
    n_checks++;
    if ({ch, f} !== {2'd0, 8'hA0}) begin
      n_fail++;
      $display("[TB] FAIL manual_sel0: ch=%0d f=%h, expected ch=0 f=a0", ch, f);
    end
  endtask

  // Starts from ch=0 with a cleared dwell count; after edge k the channel
  // is (k/3) mod 4 and wrap marks every 12th edge.
  task automatic test_scan_dwell();
    int ec;
    mode = 1'b1;
    en   = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      ec = (k / 3) % 4;
      n_checks++;
      if ({ch, f, wrap} !== {2'(ec), data4(ec), (k % 12 == 0)}) begin
        n_fail++;
        $display("[TB] FAIL scan_dwell k=%0d: ch=%0d f=%h wrap=%b, expected ch=%0d f=%h wrap=%b",
                 k, ch, f, wrap, ec, data4(ec), (k % 12 == 0));
      end
    end
  endtask

  task automatic test_enable_gating();
    int ch1_cycles = 0;
    int exp_seq[4] = '{0, 0, 1, 1};
    for (int k = 0; k < 4; k++) begin
      step();
      if (ch == 2'd1) ch1_cycles++;
      n_checks++;
      if ({ch, wrap} !== {2'(exp_seq[k]), 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL gate_pre k=%0d: ch=%0d wrap=%b, expected ch=%0d wrap=0", k, ch, wrap, exp_seq[k]);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (ch == 2'd1) ch1_cycles++;
      n_checks++;
      if ({ch, f, wrap} !== {2'd1, 8'hB1, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL gate_hold k=%0d: ch=%0d f=%h wrap=%b, expected ch=1 f=b1 wrap=0", k, ch, f, wrap);
      end
    end
    en = 1'b1;
    step();
    if (ch == 2'd1) ch1_cycles++;
    step();
    n_checks++;
    if ({ch, f, wrap} !== {2'd2, 8'hC2, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL gate_advance: ch=%0d f=%h wrap=%b, expected ch=2 f=c2 wrap=0", ch, f, wrap);
    end
    n_checks++;
    if (ch1_cycles !== 8) begin
      n_fail++;
      $display("[TB] FAIL gate_ch1_cycles: got %0d, expected 8", ch1_cycles);
    end
  endtask

  task automatic test_mode_switch();
    int exp_seq[4] = '{2, 2, 3, 3};
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (ch !== 2'(exp_seq[k])) begin
        n_fail++;
        $display("[TB] FAIL switch_pre k=%0d: ch=%0d, expected %0d", k, ch, exp_seq[k]);
      end
    end
    mode = 1'b0;
    sel  = 2'd1;
    step();
    n_checks++;
    if ({ch, f, wrap} !== {2'd1, 8'hB1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL switch_to_manual: ch=%0d f=%h wrap=%b, expected ch=1 f=b1 wrap=0", ch, f, wrap);
    end
    mode = 1'b1;
    exp_seq = '{1, 1, 2, 2};
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({ch, f, wrap} !== {2'(exp_seq[k]), data4(exp_seq[k]), 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL switch_to_scan k=%0d: ch=%0d f=%h wrap=%b, expected ch=%0d f=%h wrap=0",
                 k, ch, f, wrap, exp_seq[k], data4(exp_seq[k]));
      end
    end
  endtask

  task automatic test_async_reset();
    int exp_seq[3] = '{0, 0, 1};
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ch, f, wrap} !== {2'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL async_reset_immediate: ch=%0d f=%h wrap=%b, expected 0/00/0", ch, f, wrap);
    end
    step();
    n_checks++;
    if ({ch, f, wrap} !== {2'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL async_reset_held: ch=%0d f=%h wrap=%b, expected 0/00/0", ch, f, wrap);
    end
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({ch, f, wrap} !== {2'(exp_seq[k]), data4(exp_seq[k]), 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL async_reset_restart k=%0d: ch=%0d f=%h wrap=%b, expected ch=%0d f=%h wrap=0",
                 k, ch, f, wrap, exp_seq[k], data4(exp_seq[k]));
      end
    end
  endtask

  task automatic test_boundary_n3();
    int ec;
    @(negedge clk);
    rst3_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      ec = k % 3;
      n_checks++;
      if ({ch3, f3, wrap3} !== {2'(ec), data3(ec), (ec == 0)}) begin
        n_fail++;
        $display("[TB] FAIL n3_scan k=%0d: ch=%0d f=%h wrap=%b, expected ch=%0d f=%h wrap=%b",
                 k, ch3, f3, wrap3, ec, data3(ec), (ec == 0));
      end
    end
    mode3 = 1'b0;
    sel3  = 2'd1;
    step();
    n_checks++;
    if ({ch3, f3, wrap3} !== {2'd1, 8'h22, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL n3_manual_sel1: ch=%0d f=%h wrap=%b, expected ch=1 f=22 wrap=0", ch3, f3, wrap3);
    end
    sel3 = 2'd3;
    step();
    step();
    n_checks++;
    if ({ch3, f3, wrap3} !== {2'd1, 8'h22, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL n3_manual_sel3_ignored: ch=%0d f=%h wrap=%b, expected ch=1 f=22 wrap=0", ch3, f3, wrap3);
    end
    sel3 = 2'd2;
    step();
    n_checks++;
    if ({ch3, f3} !== {2'd2, 8'h33}) begin
      n_fail++;
      $display("[TB] FAIL n3_manual_sel2: ch=%0d f=%h, expected ch=2 f=33", ch3, f3);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    din    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    mode   = 1'b0;
    sel    = 2'd0;
    en     = 1'b0;
    rst3_n = 1'b0;
    din3   = {8'h33, 8'h22, 8'h11};
    mode3  = 1'b1;
    sel3   = 2'd0;
    en3    = 1'b1;

    test_reset();
    test_manual();
    test_scan_dwell();
    test_enable_gating();
    test_mode_switch();
    test_async_reset();
    test_boundary_n3();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_mux.md
# tdm_mux

Parametrised, registered N-channel, W-bit multiplexer with two modes: manual select and automatic time-division scan. In scan mode it steps through the channels and dwells a programmable number of enabled cycles on each one. It flags each wrap of the scan. It replaces the fixed 1-bit 4:1 combinational mux wherever a clocked, wider or wider-fan-in selector with autonomous sequencing is needed.

## Interface
Parameters:
- N_CH, 4, number of input channels; N_CH >= 2
- W, 1, bits per channel; W >= 1
- DWELL, 1, enabled cycles spent on each channel in scan mode; DWELL >= 1
- SEL_W (local), $clog2(N_CH), width of channel index
- CNT_W (local), max(1, $clog2(DWELL)), width of dwell counter

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  N_CH*W  packed channels; channel k occupies din[k*W +: W]
- mode  in  1  0 = MANUAL, 1 = SCAN; sampled at every edge
- sel  in  SEL_W  channel request in MANUAL mode
- en  in  1  scan advance enable; ignored in MANUAL
- f  out  W  registered selected data
- ch  out  SEL_W  registered index of the channel currently driving f
- wrap  out  1  one-cycle pulse: scan moved from channel N_CH-1 to channel 0

## Operation
- State: ch (SEL_W), cnt (CNT_W), wrap, f. The FSM is implied by mode: MANUAL when mode=0 at the edge, SCAN when mode=1.
- Reset (rst_n=0, immediate, clock-independent): f=0, ch=0, cnt=0, wrap=0.
- MANUAL (mode=0) at each edge:
  - If sel < N_CH: ch_next = sel. Otherwise ch_next = ch; an out-of-range request is ignored.
  - cnt <= 0; wrap <= 0.
- SCAN (mode=1), en=0: ch_next = ch; cnt holds; wrap <= 0.
- SCAN (mode=1), en=1, cnt < DWELL-1: ch_next = ch; cnt <= cnt+1; wrap <= 0.
- SCAN (mode=1), en=1, cnt == DWELL-1:
  - cnt <= 0.
  - ch_next = (ch == N_CH-1) ? 0 : ch+1.
  - wrap <= (ch == N_CH-1).
- Every edge, all modes: ch <= ch_next; f <= din[ch_next*W +: W]. f and ch always describe the same channel in the same cycle.
- Mode switches:
  - MANUAL→SCAN: scanning starts from the current ch with cnt=0, so the first dwell is full length.
  - SCAN→MANUAL: the partial dwell is discarded and ch follows sel at that edge.
- DWELL=1: ch advances on every enabled cycle.
- Non-power-of-two N_CH: the wrap is explicit at N_CH-1, so indices >= N_CH never appear on ch.

## Timing
- Latency: one clock from a din, sel or mode change to f/ch. There is no combinational path from inputs to outputs.
- f tracks din changes on the current channel one cycle later, including while dwelling or while en=0.
- In SCAN with en held high, each channel drives f for exactly DWELL consecutive cycles. A full scan lasts N_CH*DWELL cycles; wrap pulses once per scan, in the first cycle ch=0 is visible.
- en low stretches the dwell by exactly the number of low cycles and never drops or repeats a count.
- Reset asserted mid-scan: outputs clear immediately. After release, the first edge behaves as a fresh start: MANUAL gives ch=sel; SCAN gives ch=0 with a full DWELL on channel 0. No wrap pulse is produced by reset.
- wrap never asserts in MANUAL, or in SCAN when en=0.

## Test plan
- Reset and MANUAL: N_CH=4, W=8, din={8'hD3,8'hC2,8'hB1,8'hA0}, mode=0. Hold rst_n=0 → f=0, ch=0, wrap=0. Release, then sel=2 → one edge later ch=2, f=8'hC2. Change din channel 2 to 8'h55 → next cycle f=8'h55.
- Scan dwell: DWELL=3, mode=1, en=1 from ch=0.
  - ch sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0…
  - f follows 8'hA0/B1/C2/D3.
  - wrap is high only in the cycle ch first returns to 0, i.e. every 12 cycles.
- Enable gating: DWELL=3, SCAN. Drop en for 5 cycles after the second cycle on ch=1 → ch stays 1 for 3+5=8 cycles total, then advances to 2. No wrap.
- Mode switching: scan to ch=3, cnt=1, then mode=0 with sel=1 → next edge ch=1. Return to mode=1 → ch=1 is held for a full 3 cycles, then 2.
- Boundaries:
  - N_CH=3, DWELL=1, SCAN: ch cycles 0,1,2,0 and never shows 3; wrap every 3rd cycle.
  - MANUAL with sel=3: ch keeps its previous value.
- Async reset mid-operation: assert rst_n low between clock edges during a SCAN dwell → f, ch, wrap clear immediately, before the next edge. After release with mode=1: full DWELL on channel 0.
